// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a datapath and the serial adder controller.
// SERIAL_ADD_SUB_EN adds the sub request line.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`endif

endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder shared by the serial controller.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first, WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to enable subtraction via the sub request line.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    serial_add_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and seed the carry with one.
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub | bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                accept   = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= {s_bit, res[WIDTH-1:1]};
            carry <= c_bit;
            if (last) begin
                // carry is the MSB carry-in on the final bit
                cout_q <= c_bit;
                ovf_q  <= carry ^ c_bit;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = res;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vectors, random, corners.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub ignored in add-only build");
`endif
    endtask

    // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        logic [7:0] yy;
        logic       cc;
        logic [8:0] r;
        logic       v;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, yy} + {8'd0, cc};
        v  = (x[7] == yy[7]) && (r[7] != x[7]);
        return {r[8], v, r[7:0]};
    endfunction

    // Returns at the negedge where done is seen; lat counts cycles from the
    // acceptance edge, so the expected value is W+1.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic s, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.cin   = c;
        set_sub(s);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.cin   = 1'($urandom);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
    endtask

    vec_t       vecs[$];
    int         lat;
    logic [9:0] exp;
    int         dcount;
    int         bad;
    int         didx[$];
    logic [7:0] dsum[$];

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        set_sub(1'b0);
        rst = 1'b1;

        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum",  32'(bus.sum),  0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_ovf",  32'(bus.ovf),  0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_lat", i),  32'(lat), W + 1);
            check($sformatf("vec%0d_sum", i),  32'(bus.sum),  32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i),  32'(bus.ovf),  32'(vecs[i].ovf));
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 32'(bus.done), 0);
            check($sformatf("vec%0d_hold", i),  32'(bus.sum),  32'(vecs[i].sum));
        end

        for (int i = 0; i < 25; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            logic       c;
            logic       s;
            x = 8'($urandom);
            y = 8'($urandom);
            c = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            exp = model(x, y, c, s);
            run_op(x, y, c, s, lat);
            check($sformatf("rnd%0d_lat", i), 32'(lat), W + 1);
            check($sformatf("rnd%0d_res", i),
                  32'({bus.cout, bus.ovf, bus.sum}), 32'(exp));
        end

        // start mid-RUN is ignored, operand changes have no effect
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.cin   = 1'b0;
        set_sub(1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dcount++;
                check("ign_sum", 32'(bus.sum), 32'h30);
            end
        end
        check("ign_done_cnt", 32'(dcount), 1);

        // back-to-back with start held high
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        bad = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (bus.busy == bus.done) bad++;
            if (bus.done) begin
                didx.push_back(i);
                dsum.push_back(bus.sum);
            end
        end
        bus.start = 1'b0;
        check("b2b_busy", 32'(bad), 0);
        check("b2b_cnt", 32'(didx.size()), 3);
        if (didx.size() == 3) begin
            check("b2b_first", 32'(didx[0]), W);
            check("b2b_gap1", 32'(didx[1] - didx[0]), W + 1);
            check("b2b_gap2", 32'(didx[2] - didx[1]), W + 1);
        end
        foreach (dsum[i]) check($sformatf("b2b_sum%0d", i), 32'(dsum[i]), 32'h02);
        repeat (12) @(negedge clk);

        // asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_sum",  32'(bus.sum),  0);
        check("arst_cout", 32'(bus.cout), 0);
        check("arst_ovf",  32'(bus.ovf),  0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("arst_no_done", 32'(dcount), 0);
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        check("arst_new_lat", 32'(lat), W + 1);
        check("arst_new_sum", 32'(bus.sum), 32'h96);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It sequences a single 1-bit full-adder cell over `WIDTH` clock cycles to add two `WIDTH`-bit operands, LSB first, using a registered carry. It sits between a requesting datapath and the shared 1-bit adder cell, trading area for latency. Operands are captured on a start handshake; a one-cycle `done` pulse marks a valid result.

## Interface

- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only when not busy.
- `a` in `WIDTH`: operand A, captured when `start` is accepted.
- `b` in `WIDTH`: operand B, captured when `start` is accepted.
- `cin` in 1: initial carry, captured when `start` is accepted.
- `sub` in 1: subtract request. Present only with `SERIAL_ADD_SUB_EN`.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse; the result is valid.
- `sum` out `WIDTH`: result, held until the next accepted start.
- `cout` out 1: final carry-out.
- `ovf` out 1: signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation

- FSM states:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE, on `start`=1:
  - `a` → A shift register, `b` → B shift register.
  - `cin` → carry register.
  - Bit counter ← 0.
  - Go to RUN.
- RUN, each cycle:
  - The full-adder cell takes A[0], B[0] and the carry.
  - The sum bit shifts into the MSB of the result register; A and B shift right.
  - The carry register takes the cell's carry-out.
  - The counter increments.
  - When counter = `WIDTH`-1: record the cell's carry-in as the MSB carry-in (for `ovf`), then go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `sum`, `cout` and `ovf` are valid.
  - Next state is IDLE, or RUN if `start`=1 (back-to-back operation allowed).
- `start` while in RUN is ignored; there is no queuing.
- Operands are sampled only at acceptance. Changes to `a`/`b`/`cin` during RUN have no effect.
- `busy` = (state == RUN).
- Counter width is `$clog2(WIDTH)`. The counter never wraps within an operation.
- Outputs `sum`, `cout` and `ovf` are registered and held from DONE until the next acceptance. At acceptance, `sum` updates progressively as bits shift in; consumers must qualify it with `done`.
- Reset values (any time, including mid-operation):
  - state IDLE.
  - `busy`=0, `done`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - Internal registers and counter cleared.
  - The operation in flight is abandoned. There is no `done` for it.

## Timing

- `start` accepted at rising edge k. `busy` is high from k to k+`WIDTH`.
- Bit i is processed at edge k+1+i.
- `done` is high in the cycle after edge k+`WIDTH`. Latency is `WIDTH`+1 cycles from acceptance edge to `done`.
- Throughput: one operation per `WIDTH`+1 cycles with back-to-back `start`.
- `start` asserted in the DONE cycle is accepted at the next edge; `done` deasserts at that same edge.
- `rst` asserted asynchronously forces the reset values immediately, without waiting for a clock edge.

## Configuration

- Macro: `SERIAL_ADD_SUB_EN`.
- Defined:
  - The `sub` port exists.
  - At acceptance with `sub`=1, B is captured as ~`b` and the carry is seeded with 1; `cin` is ignored.
  - `cout`=1 means no borrow.
  - `ovf` follows the same XOR rule.
  - With `sub`=0, behaviour is identical to the add-only build.
- Undefined:
  - No `sub` port.
  - Add-only behaviour, with `cin` always used.

## Structure

- Shared package `serial_add_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Default `WIDTH` constant.
- One sub-module, `fa_cell`:
  - Combinational 1-bit full adder.
  - Inputs `a`, `b`, `ci`; outputs `s`, `co`.
  - Instantiated once, with its inputs driven from the LSBs of the A/B shift registers and the carry register.

## Test plan

All scenarios use `WIDTH`=8.

1. Reset → `busy`=0, `done`=0, `sum`=0x00, `cout`=0, `ovf`=0. Assert `start`=1 with 0x5A+0x3C, `cin`=0 → `done` exactly 9 cycles after the acceptance edge, `sum`=0x96, `cout`=0, `ovf`=1.
2. 0xFF+0x01, `cin`=0 → `sum`=0x00, `cout`=1, `ovf`=0. Then 0x00+0x00, `cin`=1 → `sum`=0x01, `cout`=0.
3. Start 0x10+0x20, then pulse `start` with 0xFF+0xFF at cycle 3 of RUN → only one `done`, with `sum`=0x30. Operand changes mid-RUN have no effect.
4. Hold `start`=1 continuously with 0x01+0x01 → `done` pulses every 9 cycles, each with `sum`=0x02; `busy` is low only during DONE.
5. Assert `rst` at cycle 4 of RUN → outputs return to reset values immediately and no `done` follows. A new `start` then completes normally.
6. With `SERIAL_ADD_SUB_EN`:
   - `sub`=1, 0x10−0x01 → `sum`=0x0F, `cout`=1.
   - 0x00−0x01 → `sum`=0xFF, `cout`=0.
   - 0x80−0x01 → `sum`=0x7F, `ovf`=1.
